// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and a synchronous clear.
module sync_fifo_param #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd_enb,
    output logic [WIDTH-1:0]           dout,
    output logic                       fullreg,
    output logic                       emptyreg,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_full;
    logic             r_empty;
    logic             r_afull;
    logic             r_aempty;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_wacc;
    logic             w_racc;
    logic [CW-1:0]    w_count_next;

    // Acceptance uses the flags registered before this edge.
    assign w_wacc = wr_en  & ~r_full;
    assign w_racc = rd_enb & ~r_empty;

    always_comb begin
        w_count_next = r_count;
        if (clr) begin
            w_count_next = '0;
        end else if (w_wacc && !w_racc) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_wacc && w_racc) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wacc && !clr) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_dout      <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= (AF_THRESH == 0);
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count  <= w_count_next;
            // Flags come from the next count so they always agree with count.
            r_full   <= (w_count_next == CW'(DEPTH));
            r_empty  <= (w_count_next == '0);
            r_afull  <= (w_count_next >= CW'(AF_THRESH));
            r_aempty <= (w_count_next <= CW'(AE_THRESH));
            if (clr) begin
                r_wptr      <= '0;
                r_rptr      <= '0;
                r_dout      <= '0;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                if (w_wacc) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_racc) begin
                    r_rptr <= r_rptr + AW'(1);
                    r_dout <= r_mem[r_rptr];
                end
                if (wr_en && r_full) begin
                    r_overflow <= 1'b1;
                end
                if (rd_enb && r_empty) begin
                    r_underflow <= 1'b1;
                end
            end
        end
    end

    assign dout         = r_dout;
    assign count        = r_count;
    assign fullreg      = r_full;
    assign emptyreg     = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param; a queue-based reference model
// predicts each cycle's outputs and a monitor compares them one cycle later.
module tb_sync_fifo_param;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int AF    = DEPTH - 1;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             clr;
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_enb;
    logic [WIDTH-1:0] dout;
    logic             fullreg;
    logic             emptyreg;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    sync_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .din(din),
        .rd_enb(rd_enb), .dout(dout), .fullreg(fullreg), .emptyreg(emptyreg),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]      id;
        logic [WIDTH-1:0] dout;
        logic [CW-1:0]    count;
        logic             full;
        logic             empty;
        logic             af;
        logic             ae;
        logic             ov;
        logic             un;
    } exp_t;

    exp_t             expq[$];
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_ov;
    logic             m_un;
    int               tests = 0;
    int               fails = 0;
    int               step_id = 0;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_ov   = 1'b0;
        m_un   = 1'b0;
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the edge.
    task automatic step(input logic w, input logic r, input logic c, input logic [WIDTH-1:0] d);
        exp_t e;
        logic full;
        logic empty;
        @(negedge clk);
        wr_en = w; rd_enb = r; clr = c; din = d;
        if (c) begin
            model_reset();
        end else begin
            full  = (mq.size() == DEPTH);
            empty = (mq.size() == 0);
            if (w && full)  m_ov = 1'b1;
            if (r && empty) m_un = 1'b1;
            if (r && !empty) m_dout = mq.pop_front();
            if (w && !full) mq.push_back(d);
        end
        e.id    = 16'(step_id);
        e.dout  = m_dout;
        e.count = CW'(mq.size());
        e.full  = (mq.size() == DEPTH);
        e.empty = (mq.size() == 0);
        e.af    = (mq.size() >= AF);
        e.ae    = (mq.size() <= AE);
        e.ov    = m_ov;
        e.un    = m_un;
        expq.push_back(e);
        step_id++;
    endtask

    // Idle the inputs and wait, with a cycle budget, for the monitor to catch up.
    task automatic drain();
        @(negedge clk);
        wr_en = 1'b0; rd_enb = 1'b0; clr = 1'b0;
        for (int i = 0; i < 20 && expq.size() != 0; i++) @(posedge clk);
        #2;
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expq.size());
            expq.delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_empty"}, int'(emptyreg), 1);
        chk({tag, "_full"}, int'(fullreg), 0);
        chk({tag, "_ae"}, int'(almost_empty), 1);
        chk({tag, "_af"}, int'(almost_full), 0);
        chk({tag, "_dout"}, int'(dout), 0);
        chk({tag, "_ov"}, int'(overflow), 0);
        chk({tag, "_un"}, int'(underflow), 0);
    endtask

    // Monitor: compares every queued expectation one delta after the clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                tests++;
                if (dout !== e.dout || count !== e.count || fullreg !== e.full ||
                    emptyreg !== e.empty || almost_full !== e.af || almost_empty !== e.ae ||
                    overflow !== e.ov || underflow !== e.un) begin
                    fails++;
                    $display("[TB] FAIL step%0d: got dout=%h cnt=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b expected dout=%h cnt=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b",
                             e.id, dout, count, fullreg, emptyreg, almost_full, almost_empty,
                             overflow, underflow, e.dout, e.count, e.full, e.empty, e.af,
                             e.ae, e.ov, e.un);
                end else begin
                    $display("[TB] step%0d ok dout=%h cnt=%0d ov=%b un=%b",
                             e.id, dout, count, overflow, underflow);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_enb = 1'b0; din = '0;
        model_reset();
        #1;
        check_reset_vals("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Fill, overflow, drain, underflow, then clear.
        step(1, 0, 0, 16'hB94E);
        step(1, 0, 0, 16'h0001);
        step(1, 0, 0, 16'h0002);
        step(1, 0, 0, 16'h0003);
        step(1, 0, 0, 16'hDEAD);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 16'h0000);
        step(0, 0, 0, 16'h0000);
        step(0, 0, 1, 16'h0000);

        // Simultaneous read/write at count 2, then at full and at empty.
        step(1, 0, 0, 16'h0100);
        step(1, 0, 0, 16'h0101);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 16'(16'h0102 + i));
        step(1, 0, 0, 16'h0200);
        step(1, 0, 0, 16'h0201);
        step(1, 1, 0, 16'h0202);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0000);
        step(1, 1, 0, 16'h0300);
        step(0, 1, 0, 16'h0000);
        step(0, 0, 1, 16'h0000);

        // Pointer wrap.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 16'(16'h0A00 + i));
        for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0000);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 16'(16'h0B00 + i));
        for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h0000);

        // Clear wins over a same-cycle write and read.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 16'(16'h0C00 + i));
        step(1, 1, 1, 16'h0CFF);
        step(0, 1, 0, 16'h0000);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 3, 16'($urandom));
        end

        // Asynchronous reset mid-stream.
        step(1, 0, 0, 16'h5A5A);
        step(1, 0, 0, 16'hA5A5);
        step(1, 1, 0, 16'h1234);
        drain();
        @(negedge clk);
        #1;
        reset = 1'b1;
        wr_en = 1'b1; din = 16'hFFFF;
        #1;
        model_reset();
        check_reset_vals("midrst");
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("rsthold");
        reset = 1'b0;
        step(0, 0, 0, 16'h0000);
        step(1, 0, 0, 16'h7777);
        step(0, 1, 0, 16'h0000);
        step(0, 1, 0, 16'h0000);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
